// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the alarm clock core.
package clock_pkg;

  localparam logic [3:0] DigitMax    = 4'd9;
  localparam logic [3:0] TensMax     = 4'd5;
  localparam logic [3:0] HourTensMax = 4'd2;
  localparam logic [3:0] HourUnitMax = 4'd3;  // units limit once the tens digit is 2

  typedef logic [15:0] hhmm_t;
  typedef logic [23:0] hms_t;

  typedef enum logic [1:0] {StIdle, StRing, StSnooze} ring_state_e;

  function automatic logic bcd_hhmm_valid(hhmm_t v);
    logic [3:0] h1, h0, m1, m0;
    logic       hour_ok;
    h1 = v[15:12];
    h0 = v[11:8];
    m1 = v[7:4];
    m0 = v[3:0];
    hour_ok = (h1 < HourTensMax && h0 <= DigitMax) || (h1 == HourTensMax && h0 <= HourUnitMax);
    return hour_ok && (m1 <= TensMax) && (m0 <= DigitMax);
  endfunction

  function automatic logic bcd_hms_valid(hms_t v);
    return bcd_hhmm_valid(v[23:8]) && (v[7:4] <= TensMax) && (v[3:0] <= DigitMax);
  endfunction

  // mins is at most 59, so one carry into the hours is enough.
  function automatic hhmm_t hhmm_add_min(hhmm_t v, int unsigned mins);
    int unsigned h, m;
    h = 10 * 32'(v[15:12]) + 32'(v[11:8]);
    m = 10 * 32'(v[7:4]) + 32'(v[3:0]) + mins;
    if (m >= 60) begin
      m = m - 60;
      h = h + 1;
    end
    if (h >= 24) h = h - 24;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Prescaler and BCD HH:MM:SS counter with validated load path.
module bcd_time_counter import clock_pkg::*; #(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic load,
  input  hms_t load_val,
  output logic load_ok,
  output logic tick,
  output hms_t time_next,
  output hms_t time_out,
  output logic sec_pulse
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  hms_t          time_q, time_d;
  logic          pulse_q;

  function automatic hms_t hms_inc(hms_t t);
    hms_t r;
    r = t;
    if (t[3:0] != DigitMax) begin
      r[3:0] = t[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (t[7:4] != TensMax) begin
        r[7:4] = t[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (t[11:8] != DigitMax) begin
          r[11:8] = t[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
          if (t[15:12] != TensMax) begin
            r[15:12] = t[15:12] + 4'd1;
          end else begin
            r[15:12] = 4'd0;
            if (t[23:16] == 8'h23) begin
              r[23:16] = 8'h00;
            end else if (t[19:16] == DigitMax) begin
              r[19:16] = 4'd0;
              r[23:20] = t[23:20] + 4'd1;
            end else begin
              r[19:16] = t[19:16] + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  assign load_ok   = load && bcd_hms_valid(load_val);
  // An accepted load swallows a tick that would land in the same cycle.
  assign tick      = run && !load_ok && (presc_q == PrescLast);
  assign time_next = hms_inc(time_q);

  always_comb begin
    presc_d = presc_q;
    time_d  = time_q;
    if (load_ok) begin
      presc_d = '0;
      time_d  = load_val;
    end else if (tick) begin
      presc_d = '0;
      time_d  = time_next;
    end else if (run) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      time_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      time_q  <= time_d;
      pulse_q <= tick;
    end
  end

  assign time_out  = time_q;
  assign sec_pulse = pulse_q;

endmodule

// File: rtl/multi_alarm_clock.sv
// Timekeeping core with N alarm slots, snooze and ring timeout.
module multi_alarm_clock import clock_pkg::*; #(
  parameter int unsigned CLK_DIV    = 50_000_000,
  parameter int unsigned N_ALARM    = 4,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60,
  localparam int unsigned IW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          time_wr,
  input  logic [23:0]   time_in,
  input  logic          alm_wr,
  input  logic [IW-1:0] alm_idx,
  input  logic [16:0]   alm_in,
  input  logic [IW-1:0] alm_rd_idx,
  output logic [16:0]   alm_rd_out,
  input  logic          stop,
  input  logic          snooze,
  output logic [23:0]   time_out,
  output logic          sec_pulse,
  output logic          ring,
  output logic [IW-1:0] ring_idx
);

  localparam logic [7:0] RingLimit = 8'(RING_SEC);

  logic        time_loaded;
  logic        tick;
  hms_t        time_next;

  logic [16:0] alarm_q [N_ALARM];
  logic        alm_ok;

  logic          match_hit, match_event, snooze_hit, at_minute;
  logic [IW-1:0] match_idx;

  ring_state_e   state_q, state_d;
  logic [IW-1:0] ring_idx_q, ring_idx_d;
  logic [7:0]    ring_cnt_q, ring_cnt_d;
  hhmm_t         snooze_tgt_q, snooze_tgt_d;

  bcd_time_counter #(
    .CLK_DIV (CLK_DIV)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .load      (time_wr),
    .load_val  (time_in),
    .load_ok   (time_loaded),
    .tick      (tick),
    .time_next (time_next),
    .time_out  (time_out),
    .sec_pulse (sec_pulse)
  );

  // Out-of-range indices match no slot, so such writes fall through untouched.
  assign alm_ok = alm_wr && bcd_hhmm_valid(alm_in[15:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ALARM; i++) alarm_q[i] <= '0;
    end else if (alm_ok) begin
      for (int i = 0; i < N_ALARM; i++) begin
        if (alm_idx == IW'(i)) alarm_q[i] <= alm_in;
      end
    end
  end

  always_comb begin
    alm_rd_out = '0;
    for (int i = 0; i < N_ALARM; i++) begin
      if (alm_rd_idx == IW'(i)) alm_rd_out = alarm_q[i];
    end
  end

  // Scan from the top so the lowest matching slot is the last to land.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (alarm_q[i][16] && (alarm_q[i][15:0] == time_next[23:8])) begin
        match_hit = 1'b1;
        match_idx = IW'(i);
      end
    end
  end

  assign at_minute   = tick && (time_next[7:0] == 8'h00);
  assign match_event = at_minute && match_hit;
  assign snooze_hit  = at_minute && (time_next[23:8] == snooze_tgt_q);

  always_comb begin
    state_d      = state_q;
    ring_idx_d   = ring_idx_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_tgt_d = snooze_tgt_q;
    unique case (state_q)
      StIdle: begin
        if (match_event) begin
          state_d    = StRing;
          ring_idx_d = match_idx;
          ring_cnt_d = '0;
        end
      end
      StRing: begin
        if (time_loaded || stop) begin
          state_d = StIdle;
        end else if (snooze) begin
          state_d      = StSnooze;
          snooze_tgt_d = hhmm_add_min(time_out[23:8], SNOOZE_MIN);
        end else if (tick) begin
          ring_cnt_d = ring_cnt_q + 8'd1;
          if (ring_cnt_q + 8'd1 == RingLimit) state_d = StIdle;
        end
      end
      StSnooze: begin
        if (time_loaded || stop) begin
          state_d = StIdle;
        end else if (match_event) begin
          state_d    = StRing;
          ring_idx_d = match_idx;
          ring_cnt_d = '0;
        end else if (snooze_hit) begin
          state_d    = StRing;
          ring_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ring_idx_q   <= '0;
      ring_cnt_q   <= '0;
      snooze_tgt_q <= '0;
    end else begin
      state_q      <= state_d;
      ring_idx_q   <= ring_idx_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_tgt_q <= snooze_tgt_d;
    end
  end

  assign ring     = (state_q == StRing);
  assign ring_idx = ring_idx_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Scoreboard bench: a seconds-of-day reference model predicts each edge, a monitor checks.
module tb_multi_alarm_clock;

  localparam int CLK_DIV    = 4;
  localparam int N_ALARM    = 4;
  localparam int SNOOZE_MIN = 5;
  localparam int RING_SEC   = 3;

  logic        clk = 1'b0;
  logic        rst, run, time_wr, alm_wr, stop, snooze;
  logic [23:0] time_in, time_out;
  logic [1:0]  alm_idx, alm_rd_idx, ring_idx;
  logic [16:0] alm_in, alm_rd_out;
  logic        sec_pulse, ring;

  always #5 clk = ~clk;

  multi_alarm_clock #(
    .CLK_DIV    (CLK_DIV),
    .N_ALARM    (N_ALARM),
    .SNOOZE_MIN (SNOOZE_MIN),
    .RING_SEC   (RING_SEC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .time_wr    (time_wr),
    .time_in    (time_in),
    .alm_wr     (alm_wr),
    .alm_idx    (alm_idx),
    .alm_in     (alm_in),
    .alm_rd_idx (alm_rd_idx),
    .alm_rd_out (alm_rd_out),
    .stop       (stop),
    .snooze     (snooze),
    .time_out   (time_out),
    .sec_pulse  (sec_pulse),
    .ring       (ring),
    .ring_idx   (ring_idx)
  );

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time as seconds of day, alarms as minutes of day.
  int          m_secs, m_pre, m_st, m_idx, m_cnt, m_tgt;
  bit          m_en [N_ALARM];
  int          m_min [N_ALARM];
  logic [16:0] m_raw [N_ALARM];

  typedef struct {
    bit tick;
    bit ring;
    int idx;
  } cyc_t;

  cyc_t cyc_q[$];
  int   tick_q[$];
  bit   track = 1'b0;
  cyc_t mon_e;

  function automatic logic [23:0] to_bcd(int secs);
    int h, m, s;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit decode_hms(input logic [23:0] v, output int secs);
    int d[6];
    int h, m, s;
    secs = 0;
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(v[4*i +: 4]);
      if (d[i] > 9) return 1'b0;
    end
    h = d[5] * 10 + d[4];
    m = d[3] * 10 + d[2];
    s = d[1] * 10 + d[0];
    if (h > 23 || m > 59 || s > 59) return 1'b0;
    secs = h * 3600 + m * 60 + s;
    return 1'b1;
  endfunction

  function automatic bit decode_hhmm(input logic [15:0] v, output int mins);
    int secs;
    bit ok;
    ok = decode_hms({v, 8'h00}, secs);
    mins = secs / 60;
    return ok;
  endfunction

  function automatic void model_reset();
    m_secs = 0; m_pre = 0; m_st = 0; m_idx = 0; m_cnt = 0; m_tgt = -1;
    for (int i = 0; i < N_ALARM; i++) begin
      m_en[i] = 1'b0; m_min[i] = 0; m_raw[i] = '0;
    end
  endfunction

  // State codes here: 0 idle, 1 ringing, 2 snoozing.
  function automatic void model_step(output bit tick);
    int cur_min, ns, wmin, idx;
    bit load_ok, at_min, hit;
    cur_min = m_secs / 60;
    load_ok = time_wr && decode_hms(time_in, ns);
    tick = 1'b0;
    idx = 0;
    if (load_ok) begin
      m_secs = ns;
      m_pre = 0;
    end else if (run) begin
      if (m_pre == CLK_DIV - 1) begin
        m_pre = 0;
        tick = 1'b1;
        m_secs = (m_secs + 1) % 86400;
      end else begin
        m_pre++;
      end
    end
    at_min = tick && (m_secs % 60 == 0);
    hit = 1'b0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (at_min && m_en[i] && m_min[i] == m_secs / 60) begin
        hit = 1'b1;
        idx = i;
      end
    end
    case (m_st)
      0: if (hit) begin m_st = 1; m_idx = idx; m_cnt = 0; end
      1: begin
        if (load_ok || stop) m_st = 0;
        else if (snooze) begin m_st = 2; m_tgt = (cur_min + SNOOZE_MIN) % 1440; end
        else if (tick) begin
          m_cnt++;
          if (m_cnt == RING_SEC) m_st = 0;
        end
      end
      default: begin
        if (load_ok || stop) m_st = 0;
        else if (hit) begin m_st = 1; m_idx = idx; m_cnt = 0; end
        else if (at_min && m_secs / 60 == m_tgt) begin m_st = 1; m_cnt = 0; end
      end
    endcase
    if (alm_wr && int'(alm_idx) < N_ALARM && decode_hhmm(alm_in[15:0], wmin)) begin
      m_en[alm_idx]  = alm_in[16];
      m_min[alm_idx] = wmin;
      m_raw[alm_idx] = alm_in;
    end
  endfunction

  // One clock: predict, let the edge happen, queue what the DUT must show.
  task automatic step();
    bit t;
    cyc_t e;
    model_step(t);
    @(posedge clk);
    if (track) begin
      e.tick = t;
      e.ring = (m_st == 1);
      e.idx  = m_idx;
      cyc_q.push_back(e);
      if (t) tick_q.push_back(m_secs);
    end
    #1;
    time_wr = 1'b0;
    alm_wr  = 1'b0;
    stop    = 1'b0;
    snooze  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_time(input logic [23:0] v);
    time_in = v;
    time_wr = 1'b1;
    step();
  endtask

  task automatic set_alarm(input int i, input logic [16:0] v);
    alm_idx = 2'(i);
    alm_in  = v;
    alm_wr  = 1'b1;
    step();
  endtask

  task automatic check_rd(input int i);
    alm_rd_idx = 2'(i);
    #1;
    check("alm_rd", alm_rd_out, m_raw[i]);
  endtask

  task automatic do_reset();
    track = 1'b0;
    cyc_q.delete();
    tick_q.delete();
    rst = 1'b1;
    #1;
    check("rst_time", time_out, 24'h000000);
    check("rst_pulse", sec_pulse, 1'b0);
    check("rst_ring", ring, 1'b0);
    check("rst_ring_idx", ring_idx, 2'd0);
    model_reset();
    for (int i = 0; i < N_ALARM; i++) check_rd(i);
    @(posedge clk);
    #1;
    rst = 1'b0;
    track = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sec_pulse) pulses++;
    if (cyc_q.size() > 0) begin
      mon_e = cyc_q.pop_front();
      check("sec_pulse", sec_pulse, mon_e.tick);
      check("ring", ring, mon_e.ring);
      if (mon_e.ring) check("ring_idx", ring_idx, mon_e.idx);
      if (sec_pulse) begin
        if (tick_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tick_underflow: got pulse expected none at %0t", $time);
        end else begin
          check("time_on_tick", time_out, to_bcd(tick_q.pop_front()));
        end
      end
    end
  end

  int p0, r;

  initial begin
    rst = 1'b0; run = 1'b0; time_wr = 1'b0; time_in = '0; alm_wr = 1'b0; alm_idx = '0;
    alm_in = '0; alm_rd_idx = '0; stop = 1'b0; snooze = 1'b0;
    #1;
    do_reset();

    // Midnight wrap: two ticks in eight cycles.
    p0 = pulses;
    set_time(to_bcd(23 * 3600 + 59 * 60 + 58));
    run = 1'b1;
    idle(8);
    check("wrap_time", time_out, 24'h000000);
    #5;
    check("wrap_pulses", pulses - p0, 2);

    // Illegal writes are dropped.
    run = 1'b0;
    set_time(24'h250000);
    check("bad_time", time_out, 24'h000000);
    set_alarm(2, {1'b1, 16'h1260});
    alm_rd_idx = 2'd2;
    #1;
    check("bad_alarm", alm_rd_out, 17'h0);

    // Two slots at 07:30: lowest wins, then timeout.
    set_alarm(1, {1'b1, 16'h0730});
    set_alarm(3, {1'b1, 16'h0730});
    check_rd(1);
    check_rd(3);
    set_time(to_bcd(7 * 3600 + 29 * 60 + 59));
    run = 1'b1;
    idle(4);
    check("prio_ring", ring, 1'b1);
    check("prio_idx", ring_idx, 2'd1);
    idle(4 * RING_SEC);
    check("ring_timeout", ring, 1'b0);
    run = 1'b0;
    set_alarm(1, {1'b0, 16'h0730});
    set_alarm(3, {1'b0, 16'h0730});

    // Snooze across midnight.
    set_alarm(0, {1'b1, 16'h2358});
    set_time(to_bcd(23 * 3600 + 57 * 60 + 59));
    run = 1'b1;
    idle(4);
    check("s4_ring", ring, 1'b1);
    snooze = 1'b1;
    step();
    check("s4_snoozed", ring, 1'b0);
    idle(1199);
    check("s4_rering", ring, 1'b1);
    check("s4_rering_idx", ring_idx, 2'd0);
    check("s4_rering_time", time_out, 24'h000300);
    stop = 1'b1;
    step();
    check("s4_stopped", ring, 1'b0);

    // stop beats snooze.
    set_time(to_bcd(23 * 3600 + 57 * 60 + 59));
    idle(4);
    check("s5_ring", ring, 1'b1);
    stop = 1'b1;
    snooze = 1'b1;
    step();
    check("s5_stop", ring, 1'b0);
    idle(1250);
    check("s5_no_reload", ring, 1'b0);

    // Reset during snooze.
    set_time(to_bcd(23 * 3600 + 57 * 60 + 59));
    idle(4);
    check("s6_ring", ring, 1'b1);
    snooze = 1'b1;
    step();
    idle(10);
    do_reset();
    idle(800);
    check("s6_no_ring", ring, 1'b0);

    // Randomized traffic around 10:00-10:03.
    set_alarm(0, {1'b1, 16'h1001});
    set_alarm(1, {1'b1, 16'h1002});
    set_alarm(2, {1'b1, 16'h1002});
    set_time(to_bcd(10 * 3600 + 50));
    for (int k = 0; k < 2500; k++) begin
      r = int'($urandom_range(0, 199));
      run = ($urandom_range(0, 15) != 0);
      if (r < 3) begin
        if ($urandom_range(0, 9) == 0) time_in = 24'h105A00;
        else time_in = to_bcd(10 * 3600 + int'($urandom_range(0, 3)) * 60
                              + int'($urandom_range(40, 59)));
        time_wr = 1'b1;
      end else if (r < 6) begin
        alm_idx = 2'($urandom_range(0, 3));
        alm_in = {1'($urandom_range(0, 1)), 16'h1000 | 16'($urandom_range(0, 3))};
        if ($urandom_range(0, 7) == 0) alm_in[15:0] = 16'h1070;
        alm_wr = 1'b1;
      end else if (r < 9) begin
        stop = 1'b1;
      end else if (r < 12) begin
        snooze = 1'b1;
      end else if (r < 13) begin
        stop = 1'b1;
        snooze = 1'b1;
      end
      step();
      check_rd(int'($urandom_range(0, 3)));
    end

    idle(2);
    #5;
    check("cyc_q_drained", cyc_q.size(), 0);
    check("tick_q_drained", tick_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
